// File: rtl/exe_pkg.sv
// Shared definitions for the execute path: FSM states and default widths/depth
// used by the command queue and the execute unit.
package exe_pkg;

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_ACTIVE  = 2'd1,
        S_STALLED = 2'd2
    } exe_state_t;

    localparam int EXE_M     = 4;
    localparam int EXE_N     = 2;
    localparam int EXE_DEPTH = 4;

endpackage

// File: rtl/exe_cmd_fifo.sv
// Command storage: register array addressed by wrapping read/write pointers.
// Occupancy tracking and full/empty protection are the caller's job.
module exe_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_clear,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wdata,
    output logic [W-1:0] o_rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_push) wr_ptr <= wr_ptr + 1'b1;
            if (i_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) mem[wr_ptr] <= i_wdata;
    end

    assign o_rdata = mem[rd_ptr];

endmodule

// File: rtl/exe_cmd_queue.sv
// Command queue in front of the execute unit: buffers upstream commands and
// issues them in order through a registered output stage with a one-cycle strobe.
module exe_cmd_queue
    import exe_pkg::*;
#(
    parameter int m     = EXE_M,
    parameter int n     = EXE_N,
    parameter int DEPTH = EXE_DEPTH
) (
    input  logic                       i_clk,
    input  logic                       i_rsn,
    input  logic                       i_valid,
    input  logic [n-1:0]               i_oper,
    input  logic signed [m-1:0]        i_argA,
    input  logic signed [m-1:0]        i_argB,
    output logic                       o_ready,
    input  logic                       i_flush,
    input  logic                       i_stall,
    output logic [n-1:0]               o_oper,
    output logic signed [m-1:0]        o_argA,
    output logic signed [m-1:0]        o_argB,
    output logic                       o_issue,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int W  = n + 2 * m;

    exe_state_t    state;
    logic          clear;
    logic          push;
    logic          pop;
    logic [W-1:0]  head;
    logic [CW-1:0] count_nx;

    assign o_full  = (o_count == CW'(DEPTH));
    assign o_empty = (o_count == '0);
    assign o_ready = !o_full;

    // Full blocks a push even when a pop frees a slot on the same edge.
    assign clear = i_rsn || i_flush;
    assign push  = i_valid && !o_full && !clear;
    assign pop   = !o_empty && !i_stall && !clear;

    exe_cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_clear (clear),
        .i_push  (push),
        .i_pop   (pop),
        .i_wdata ({i_oper, i_argA, i_argB}),
        .o_rdata (head)
    );

    always_comb begin
        count_nx = o_count;
        if (clear)
            count_nx = '0;
        else if (push && !pop)
            count_nx = o_count + 1'b1;
        else if (pop && !push)
            count_nx = o_count - 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rsn) begin
            state   <= S_EMPTY;
            o_count <= '0;
            o_issue <= 1'b0;
            o_oper  <= '0;
            o_argA  <= '0;
            o_argB  <= '0;
        end else begin
            o_count <= count_nx;
            o_issue <= pop;
            if (pop)
                {o_oper, o_argA, o_argB} <= head;

            // Empty is decided from the next count so state tracks o_count exactly.
            if (count_nx == '0) begin
                state <= S_EMPTY;
            end else begin
                case (state)
                    S_EMPTY:   if (push)     state <= S_ACTIVE;
                    S_ACTIVE:  if (i_stall)  state <= S_STALLED;
                    S_STALLED: if (!i_stall) state <= S_ACTIVE;
                    default:                 state <= S_EMPTY;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_exe_cmd_queue.sv
// Directed scenarios followed by random traffic, checked against a queue-based
// reference model of the command buffer.
module tb_exe_cmd_queue;

    localparam int M = 4;
    localparam int N = 2;
    localparam int D = 4;

    logic                clk = 1'b0;
    logic                rsn;
    logic                valid;
    logic                flush;
    logic                stall;
    logic [N-1:0]        oper;
    logic signed [M-1:0] arga;
    logic signed [M-1:0] argb;

    logic                o_ready;
    logic [N-1:0]        o_oper;
    logic signed [M-1:0] o_argA;
    logic signed [M-1:0] o_argB;
    logic                o_issue;
    logic [2:0]          o_count;
    logic                o_full;
    logic                o_empty;

    exe_cmd_queue #(
        .m     (M),
        .n     (N),
        .DEPTH (D)
    ) dut (
        .i_clk   (clk),
        .i_rsn   (rsn),
        .i_valid (valid),
        .i_oper  (oper),
        .i_argA  (arga),
        .i_argB  (argb),
        .o_ready (o_ready),
        .i_flush (flush),
        .i_stall (stall),
        .o_oper  (o_oper),
        .o_argA  (o_argA),
        .o_argB  (o_argB),
        .o_issue (o_issue),
        .o_count (o_count),
        .o_full  (o_full),
        .o_empty (o_empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] op;
        logic [M-1:0] a;
        logic [M-1:0] b;
    } cmd_t;

    cmd_t q[$];
    cmd_t last;
    logic exp_issue;
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check o_ready, advance the model, check outputs.
    task automatic step(input logic v, input logic [N-1:0] op, input logic [M-1:0] av,
                        input logic [M-1:0] bv, input logic st, input logic fl, input logic rs);
        bit   do_push;
        bit   do_pop;
        cmd_t c;
        valid = v;
        oper  = op;
        arga  = av;
        argb  = bv;
        stall = st;
        flush = fl;
        rsn   = rs;
        #1;
        chk("ready", {31'b0, o_ready}, {31'b0, (q.size() < D)});
        do_push   = v && (q.size() < D) && !fl && !rs;
        do_pop    = (q.size() > 0) && !st && !fl && !rs;
        exp_issue = 1'b0;
        if (rs) begin
            q.delete();
            last = '0;
        end else if (fl) begin
            q.delete();
        end else begin
            if (do_pop) begin
                last      = q.pop_front();
                exp_issue = 1'b1;
            end
            if (do_push) begin
                c.op = op;
                c.a  = av;
                c.b  = bv;
                q.push_back(c);
            end
        end
        @(posedge clk);
        #1;
        chk("issue", {31'b0, o_issue}, {31'b0, exp_issue});
        chk("oper",  {30'b0, o_oper},  {30'b0, last.op});
        chk("argA",  {28'b0, o_argA},  {28'b0, last.a});
        chk("argB",  {28'b0, o_argB},  {28'b0, last.b});
        chk("count", {29'b0, o_count}, q.size());
        chk("full",  {31'b0, o_full},  {31'b0, (q.size() == D)});
        chk("empty", {31'b0, o_empty}, {31'b0, (q.size() == 0)});
    endtask

    task automatic push_n(input int cnt, input logic st);
        for (int i = 0; i < cnt; i++)
            step(1'b1, N'($urandom), M'($urandom), M'($urandom), st, 1'b0, 1'b0);
    endtask

    task automatic idle_n(input int cnt, input logic st);
        for (int i = 0; i < cnt; i++)
            step(1'b0, '0, '0, '0, st, 1'b0, 1'b0);
    endtask

    initial begin
        rsn   = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        stall = 1'b0;
        oper  = '0;
        arga  = '0;
        argb  = '0;
        last  = '0;
        @(posedge clk);
        #1;

        // Reset values and a single push/issue with bit-exact operands.
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 2'd3, 4'b1000, 4'b0011, 1'b0, 1'b0, 1'b0);
        idle_n(2, 1'b0);

        // Fill while stalled, offer a fifth, then drain.
        push_n(4, 1'b1);
        push_n(1, 1'b1);
        idle_n(5, 1'b0);

        // Full queue with continuous offers and no stall.
        push_n(4, 1'b1);
        push_n(6, 1'b0);
        idle_n(5, 1'b0);

        // Two entries, simultaneous push and pop across pointer wrap.
        step(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        push_n(2, 1'b1);
        push_n(6, 1'b0);
        idle_n(3, 1'b0);

        // Flush with a concurrent offer at three entries.
        push_n(3, 1'b1);
        step(1'b1, 2'd2, 4'b0101, 4'b1010, 1'b0, 1'b1, 1'b0);
        idle_n(3, 1'b0);

        // Reset mid-stream while issuing.
        push_n(3, 1'b1);
        push_n(1, 1'b0);
        step(1'b1, 2'd1, 4'b1111, 4'b0001, 1'b0, 1'b0, 1'b1);
        idle_n(3, 1'b0);

        for (int i = 0; i < 400; i++)
            step(1'($urandom_range(0, 1)), N'($urandom), M'($urandom), M'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 49) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exe_cmd_queue.md
EXE_CMD_QUEUE -- requirements
Module: exe_cmd_queue

Interface
REQ-001 The block SHALL have parameter m, default 4, meaning operand/result data width in bits.
REQ-002 The block SHALL have parameter n, default 2, meaning operation-code width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning command-buffer entries, power of two, at least 2.
REQ-004 The block SHALL have one clock, and its reset SHALL be synchronous and active-high; ports are named i_clk and i_rsn.
REQ-005 i_clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 i_rsn  input  1  synchronous active-high reset.
REQ-007 i_valid  input  1  upstream offers a command this cycle.
REQ-008 i_oper  input  n  operation code of the offered command.
REQ-009 i_argA, i_argB  input  m (signed)  operands of the offered command.
REQ-010 o_ready  output  1  queue can accept a command this cycle.
REQ-011 i_flush  input  1  discard all buffered commands.
REQ-012 i_stall  input  1  downstream execute unit cannot take a command this cycle.
REQ-013 o_oper, o_argA, o_argB  output  n, m, m  registered command driven to the execute unit's i_oper/i_argA/i_argB.
REQ-014 o_issue  output  1  one-cycle strobe: o_oper/o_argA/o_argB hold a newly issued command.
REQ-015 o_count  output  $clog2(DEPTH+1)  number of buffered commands.
REQ-016 o_full, o_empty  output  1 each  o_count==DEPTH, o_count==0.

Function
REQ-017 A push SHALL occur on a rising edge where i_valid && o_ready && !i_flush && !i_rsn.
REQ-018 o_ready SHALL be combinational: !o_full.
REQ-019 A pop SHALL occur on a rising edge where !o_empty && !i_stall && !i_flush && !i_rsn; the head entry is loaded into o_oper/o_argA/o_argB and o_issue is 1 for the following cycle only.
REQ-020 Without a pop, o_issue SHALL be 0, and o_oper/o_argA/o_argB SHALL hold their last values.
REQ-021 No fall-through: a command pushed at edge k SHALL be issued at edge k+1 at the earliest.
REQ-022 Commands SHALL issue in strict FIFO order, with no loss or duplication.
REQ-023 A simultaneous push and pop SHALL leave o_count unchanged; pointers wrap modulo DEPTH.
REQ-024 When full, no push SHALL occur even if a pop happens the same edge; the upstream retries next cycle.
REQ-025 i_flush SHALL take priority over push and pop: next cycle o_count=0, pointers=0, o_issue=0, and output registers hold.
REQ-026 The FSM SHALL have states S_EMPTY, S_ACTIVE, S_STALLED:
- S_EMPTY -> S_ACTIVE on push.
- S_ACTIVE -> S_STALLED when i_stall and o_count>0.
- S_STALLED -> S_ACTIVE when !i_stall.
- any state -> S_EMPTY when o_count becomes 0 or on flush/reset.
REQ-027 The state SHALL be consistent with the counters: S_EMPTY iff o_count==0.
REQ-028 Operands SHALL be passed bit-exact, with no sign extension or modification.

Reset
REQ-029 When i_rsn=1 at an edge, the following cycle SHALL have: state S_EMPTY, o_count=0, o_empty=1, o_full=0, o_issue=0, o_oper=0, o_argA=0, o_argB=0, and pointers 0.
REQ-030 Reset SHALL override push, pop and flush; a reset mid-stream SHALL discard all entries, and no command SHALL issue after reset until a new push.
REQ-031 o_ready SHALL be 1 in the cycle after reset.

Structure
REQ-032 Package exe_pkg SHALL hold the FSM state enum and default values for m, n and DEPTH, shared with the execute unit.
REQ-033 Storage SHALL be one sub-module, exe_cmd_fifo: a register array with read/write pointers.
REQ-034 The FSM, counter, issue register and handshake logic SHALL live in exe_cmd_queue.

Verification (m=4, n=2, DEPTH=4)
REQ-035 Reset, then push (oper=3, A=4'b1000, B=4'b0011) with i_stall=0 -> o_issue=1 one cycle after the push edge with o_argA=1000, o_argB=0011, o_oper=3; then o_count=0.
REQ-036 Four pushes with i_stall=1 -> o_full=1, o_ready=0; a 5th offer is not accepted; release stall -> four issues on consecutive cycles in order, then o_empty=1.
REQ-037 Full queue with i_valid=1 and i_stall=0 -> one issue per cycle, and a push accepted only on cycles where o_full=0.
REQ-038 Queue at 2 entries, simultaneous push+pop for 6 cycles -> o_count stays 2, pointers wrap, and the issue order matches push order.
REQ-039 Queue at 3 entries, i_flush=1 together with i_valid=1 -> next cycle o_count=0, o_issue=0, and the flushed and offered commands never issue.
REQ-040 i_rsn=1 pulsed while 3 entries are buffered and issuing -> all outputs at reset values next cycle, with no further o_issue.
